// File: rtl/jtkicker_pcm_pkg.sv
// Shared types and constants for the Yie Ar Kung-Fu PCM sample player.
package jtkicker_pcm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFull,
    StEnd
  } pcm_state_e;

  localparam logic [7:0] END_MARK = 8'hFF;
  localparam logic [7:0] OFFSET   = 8'h80;

endpackage

// File: rtl/jtkicker_pcm_fetch.sv
// ROM request side of the PCM player: address counter, rom_ok qualification and
// the one-byte prefetch buffer.
module jtkicker_pcm_fetch #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          consume,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [7:0]    buf_data,
  output logic          buf_valid,
  output logic          got
);

  logic [AW-1:0] addr_q, addr_d;
  logic          chg_q, chg_d;
  logic [7:0]    buf_q, buf_d;
  logic          valid_q, valid_d;

  assign rom_cs    = fetch & ~valid_q;
  // rom_ok may still refer to the previous address right after a change
  assign got       = rom_cs & rom_ok & ~chg_q;
  assign rom_addr  = addr_q;
  assign buf_data  = buf_q;
  assign buf_valid = valid_q;

  always_comb begin
    addr_d  = addr_q;
    chg_d   = 1'b0;
    buf_d   = buf_q;
    valid_d = valid_q;
    if (load) begin
      addr_d  = load_addr;
      chg_d   = 1'b1;
      valid_d = 1'b0;
    end else begin
      if (consume) valid_d = 1'b0;
      if (got) begin
        buf_d   = rom_data;
        valid_d = 1'b1;
        addr_d  = addr_q + AW'(1);
        chg_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      chg_q   <= 1'b0;
      buf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      chg_q   <= chg_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/jtkicker_pcm_player.sv
// 8-bit PCM sample player with gain. Define JTKICKER_PCM_LOOP_EN to loop the
// sample from its start address instead of stopping at the end marker.
module jtkicker_pcm_player
  import jtkicker_pcm_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned GW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           start,
  input  logic [AW-1:0]  start_addr,
  input  logic           stop,
  input  logic [GW-1:0]  gain,
  output logic           busy,
  output logic           rom_cs,
  output logic [AW-1:0]  rom_addr,
  input  logic [7:0]     rom_data,
  input  logic           rom_ok,
  output logic [8+GW-1:0] snd,
  output logic           sample,
  output logic           underrun
);

  localparam int unsigned SW = 8 + GW;

  pcm_state_e    state_q, state_d;
  logic [SW-1:0] snd_q, snd_d;
  logic          sample_q, sample_d;
  logic          underrun_q, underrun_d;
  logic          load, consume, got, buf_valid;
  logic [AW-1:0] load_addr;
  logic [7:0]    buf_data;

  logic signed [7:0]    sbyte;
  logic signed [GW:0]   sgain;
  logic signed [SW-1:0] prod;

  assign sbyte = buf_data ^ OFFSET;
  assign sgain = {1'b0, gain};
  // Full-scale product always fits in SW bits, so truncation is exact
  assign prod  = SW'(sbyte) * SW'(sgain);

`ifdef JTKICKER_PCM_LOOP_EN
  logic [AW-1:0] start_addr_q, start_addr_d;

  assign start_addr_d = start ? start_addr : start_addr_q;
  assign load_addr    = start ? start_addr : start_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_addr_q <= '0;
    else        start_addr_q <= start_addr_d;
  end
`else
  assign load_addr = start_addr;
`endif

  jtkicker_pcm_fetch #(
    .AW (AW)
  ) u_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (state_q == StFetch),
    .load      (load),
    .load_addr (load_addr),
    .consume   (consume),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .buf_data  (buf_data),
    .buf_valid (buf_valid),
    .got       (got)
  );

  always_comb begin
    state_d    = state_q;
    snd_d      = snd_q;
    sample_d   = 1'b0;
    underrun_d = underrun_q;
    load       = 1'b0;
    consume    = 1'b0;
    if (start) begin
      state_d    = StFetch;
      load       = 1'b1;
      underrun_d = 1'b0;
    end else if (stop) begin
      state_d = StIdle;
      snd_d   = '0;
    end else begin
      case (state_q)
        StFetch: begin
          // Empty buffer at cen: repeat the last sample and flag it
          if (cen) begin
            sample_d   = 1'b1;
            underrun_d = 1'b1;
          end
          if (got) state_d = StFull;
        end
        StFull: begin
          if (cen && buf_valid) begin
            if (buf_data == END_MARK) begin
`ifdef JTKICKER_PCM_LOOP_EN
              load    = 1'b1;
              state_d = StFetch;
`else
              state_d = StEnd;
`endif
            end else begin
              snd_d    = prod;
              sample_d = 1'b1;
              consume  = 1'b1;
              state_d  = StFetch;
            end
          end
        end
        StEnd: begin
          snd_d   = '0;
          state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      snd_q      <= '0;
      sample_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snd_q      <= snd_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign snd      = snd_q;
  assign sample   = sample_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_jtkicker_pcm_player.sv
// Self-checking bench for jtkicker_pcm_player: ROM model with variable latency and
// stale-ok glitches, randomized streams checked against a byte-list reference model.
module tb_jtkicker_pcm_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic        stop = 1'b0;
  logic [3:0]  gain = '0;
  logic        busy;
  logic        rom_cs;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [11:0] snd;
  logic        sample;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jtkicker_pcm_player #(
    .AW (16),
    .GW (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .gain       (gain),
    .busy       (busy),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .snd        (snd),
    .sample     (sample),
    .underrun   (underrun)
  );

  // ROM model: ok after lat stable cycles; a stale ok with wrong data on address change
  logic [7:0]  mem [65536];
  logic [15:0] last_addr = '0;
  int          rcnt = 0;
  int          lat = 2;

  always @(posedge clk) begin
    if (!rom_cs || rom_addr != last_addr) rcnt <= 0;
    else                                  rcnt <= rcnt + 1;
    last_addr <= rom_addr;
  end

  assign rom_ok   = rom_cs && ((rom_addr != last_addr) || (rcnt >= lat));
  assign rom_data = (rom_addr != last_addr) ? ~mem[rom_addr] : mem[rom_addr];

  // cen generator, counter restarted whenever a stream is started
  int ccnt = 0;
  int period = 10;
  bit cen_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ccnt++;
      cen = cen_en && (ccnt % period == 0);
    end
  end

  // Output monitor
  int samp_q[$];
  int base = 0;
  int max_off = 0;

  always @(negedge clk) begin
    if (sample) samp_q.push_back(int'($signed(snd)));
    if (busy && rst_n) begin
      if (((int'(rom_addr) - base) & 32'hFFFF) > max_off)
        max_off = (int'(rom_addr) - base) & 32'hFFFF;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int strm[$];

  task automatic pulse_start(input int a);
    @(posedge clk);
    #1;
    start_addr = 16'(a);
    start      = 1'b1;
    ccnt       = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_strm(input int a);
    logic [15:0] ad;
    for (int i = 0; i < strm.size(); i++) begin
      ad = 16'(a + i);
      mem[ad] = 8'(strm[i]);
    end
    ad = 16'(a + strm.size());
    mem[ad] = 8'($urandom_range(0, 254));
  endtask

  task automatic wait_idle(input string tag);
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (busy && budget < 3000);
    check(tag, int'(busy), 0);
  endtask

  // Reference: every byte before the first FF plays as (byte-128)*gain
  task automatic run_stream(input int a, input int g, input int l, input int per, input bit ur);
    int exp_q[$];
    int idx, holds, bad, last;
    for (int i = 0; i < strm.size(); i++) begin
      if (strm[i] == 255) break;
      exp_q.push_back((strm[i] - 128) * g);
    end
    load_strm(a);
    lat     = l;
    period  = per;
    cen_en  = 1'b1;
    gain    = 4'(g);
    samp_q.delete();
    base    = a & 32'hFFFF;
    max_off = 0;
    pulse_start(a);
    wait_idle("done");
    repeat (3) @(negedge clk);
    if (!ur) begin
      check("nsamp", samp_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < samp_q.size(); i++)
        check("samp", samp_q[i], exp_q[i]);
      check("no_underrun", int'(underrun), 0);
    end else begin
      idx = 0; holds = 0; bad = 0; last = 0;
      foreach (samp_q[i]) begin
        if (idx < exp_q.size() && samp_q[i] == exp_q[idx]) begin
          last = samp_q[i];
          idx++;
        end else if (samp_q[i] == last) holds++;
        else bad++;
      end
      check("ur_bad", bad, 0);
      check("ur_seq", idx, exp_q.size());
      check("ur_hold", (holds > 0) ? 1 : 0, 1);
      check("ur_flag", int'(underrun), 1);
    end
    check("snd_end", int'($signed(snd)), 0);
    check("addr_bound", (max_off <= strm.size()) ? 1 : 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rom_cs", int'(rom_cs), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_snd", int'(snd), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef JTKICKER_PCM_LOOP_EN
    strm = '{8'h80, 8'hC0, 8'h40, 8'hFF};
    run_stream(32'h100, 1, 3, 10, 1'b0);
    strm = '{8'h00, 8'hFF, 8'h55, 8'h66};
    run_stream(32'h200, 15, 1, 8, 1'b0);
    strm = '{8'h10, 8'h20, 8'h30, 8'hFF};
    run_stream(32'hFFFE, 1, 2, 9, 1'b0);
    strm = '{8'h90, 8'hA0, 8'hB0, 8'hFF};
    run_stream(32'h400, 3, 20, 10, 1'b1);
    for (int r = 0; r < 6; r++) begin
      int n, l;
      n = $urandom_range(1, 6);
      l = $urandom_range(0, 5);
      strm.delete();
      for (int i = 0; i < n; i++) strm.push_back($urandom_range(0, 254));
      strm.push_back(255);
      strm.push_back($urandom_range(0, 255));
      run_stream($urandom_range(0, 65535), $urandom_range(0, 15), l,
                 l + 6 + $urandom_range(0, 4), 1'b0);
    end
`else
    strm = '{8'h80, 8'hC0, 8'h40, 8'hFF};
    load_strm(32'h100);
    lat = 2; period = 10; cen_en = 1'b1; gain = 4'd1;
    samp_q.delete();
    pulse_start(32'h100);
    begin
      int budget = 0;
      while (samp_q.size() < 9 && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
    end
    check("loop_nsamp", (samp_q.size() >= 9) ? 1 : 0, 1);
    for (int i = 0; i < 9 && i < samp_q.size(); i++)
      check("loop_samp", samp_q[i], (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 64 : -64));
    check("loop_busy", int'(busy), 1);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    check("loop_stop_busy", int'(busy), 0);
`endif

    // Stop in the middle of a sample
    strm = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFF};
    load_strm(32'h500);
    lat = 2; period = 10; gain = 4'd5;
    samp_q.delete();
    pulse_start(32'h500);
    begin
      int budget = 0;
      while (samp_q.size() < 2 && budget < 500) begin
        @(negedge clk);
        budget++;
      end
      check("stop_reach", (samp_q.size() >= 2) ? 1 : 0, 1);
    end
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    check("stop_rom_cs", int'(rom_cs), 0);
    check("stop_snd", int'(snd), 0);
    check("stop_busy", int'(busy), 0);

    // start and stop together: start wins
    strm = '{8'h81, 8'hFF};
    load_strm(32'h300);
    @(posedge clk); #1;
    start_addr = 16'h300; start = 1'b1; stop = 1'b1; ccnt = 0;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("ss_busy", int'(busy), 1);
    check("ss_rom_cs", int'(rom_cs), 1);
    check("ss_rom_addr", int'(rom_addr), 32'h300);
`ifdef JTKICKER_PCM_LOOP_EN
    repeat (30) @(negedge clk);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
`endif
    wait_idle("ss_done");

    // Asynchronous reset while fetching
    lat = 50;
    pulse_start(32'h600);
    repeat (4) @(posedge clk);
    check("pre_rst_cs", int'(rom_cs), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_rom_cs", int'(rom_cs), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtkicker_pcm_player.md
# jtkicker_pcm_player

8-bit PCM sample player for the Yie Ar Kung-Fu variant. It sits directly downstream of the PCM ROM slot of the SDRAM ROM controller and consumes the slot's address/data/ok interface. The sound CPU starts or stops a sample with register strobes. The block prefetches bytes from SDRAM and emits a signed, gain-scaled sample at each sample-rate enable, which the sound mixer consumes.

## Interface
Parameters:
- AW, 16, PCM ROM address width in bytes
- GW, 4, gain width in bits

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  sample-rate clock enable, one pulse per output sample
- start  in  1  one-cycle strobe that starts playback at start_addr
- start_addr  in  AW  first byte of the sample
- stop  in  1  one-cycle strobe that aborts playback
- gain  in  GW  unsigned output gain
- busy  out  1  high while a sample is playing
- rom_cs  out  1  ROM request
- rom_addr  out  AW  ROM byte address
- rom_data  in  8  ROM byte
- rom_ok  in  1  rom_data is valid for rom_addr
- snd  out  8+GW  signed output sample
- sample  out  1  one-cycle pulse when snd updates
- underrun  out  1  sticky flag, set when a cen arrives with no byte buffered

## Operation
- States:
  - IDLE: rom_cs=0, busy=0, snd=0.
  - FETCH: drives rom_cs=1 on rom_addr and waits for a valid rom_ok.
  - FULL: one byte is buffered; the block waits for cen.
  - END: the end marker has been reached.
- start in any state:
  - rom_addr←start_addr, buffer invalid, state→FETCH, busy=1.
  - underrun is cleared.
  - start takes priority over stop in the same cycle.
- rom_ok qualification:
  - rom_ok is ignored in the cycle rom_addr changes and is sampled from the next cycle on.
  - A qualified rom_ok latches rom_data into the buffer, advances rom_addr by 1 and moves to FULL.
  - rom_cs drops to 0 while in FULL.
- On cen in FULL:
  - If the buffered byte is 0xFF it is the end marker: no sample is output and the state→END.
  - Otherwise the byte is converted to signed (byte^0x80), multiplied by gain as an unsigned value, and the product is registered into snd with sample=1. The buffer is invalidated and the state→FETCH.
- On cen in FETCH (buffer empty):
  - snd holds its value and sample=1.
  - underrun←1.
- END:
  - snd←0 and busy←0 on the next cycle, then the state→IDLE.
- stop: state→IDLE, rom_cs←0, snd←0 on the next cycle.
- rom_addr wrap: the increment from 2^AW−1 wraps to 0 and playback continues; wrap is not an end condition.
- Arithmetic: the 8×GW product is signed, width 8+GW, with no saturation needed. gain=0 gives snd=0.

## Timing
- Reset value of every output is 0, with the state in IDLE.
- start to first rom_cs: 1 cycle.
- rom_ok to buffer valid: 1 cycle.
- cen to snd/sample: 1 cycle (registered).
- Minimum spacing between cen pulses is ROM latency + 3 cycles; shorter spacing produces underrun.
- cen arriving in the same cycle as a qualified rom_ok counts as underrun. The byte is kept for the next cen.
- Reset asserted mid-fetch drops rom_cs immediately, asynchronously.

## Configuration
- JTKICKER_PCM_LOOP_EN:
  - When defined, reaching the end marker reloads rom_addr from the start_addr latched at start and returns to FETCH. busy stays 1 until stop.
  - When undefined, the END behaviour above applies.

## Structure
- Shared package jtkicker_pcm_pkg holds:
  - the state enum (IDLE, FETCH, FULL, END);
  - the END_MARK=8'hFF constant;
  - the OFFSET=8'h80 constant.
- Sub-module jtkicker_pcm_fetch handles rom_cs, rom_addr, rom_ok qualification and the one-byte buffer. The top holds the FSM and the gain multiplier.

## Test plan
- Playback: ROM holds 80,C0,40,FF at address 0x100, gain=1, start_addr=0x100.
  - Required: snd = 0, 64, −64 on three successive cen, then 0, busy falls, and rom_addr never exceeds 0x104.
- Gain: byte 00 with gain=15 must give snd=−1920. Byte FF is never output, even mid-stream.
- Underrun: ROM ok latency of 20 cycles with cen every 10 cycles.
  - Required: underrun=1 and snd holds the previous value with sample pulses.
- Stop and restart:
  - stop mid-sample → rom_cs=0 next cycle, snd=0, busy=0.
  - start and stop in the same cycle → playback starts.
- Wrap: with AW=4 and start_addr=0xE over bytes 10,20,30,FF at 0xE,0xF,0x0,0x1.
  - Required: snd = −112, −96, −80, then end.
- Loop, with JTKICKER_PCM_LOOP_EN defined: the same ROM as the first scenario must give the sequence 0, 64, −64 repeating until stop.
